// File: rtl/burst_ring_arbiter_if.sv
// Request/response bundle for burst_ring_arbiter: per-port beats in, one arbitrated stream out.
// Slave side is the arbiter; master side drives requests and consumes the output stream.
interface burst_ring_arbiter_if #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [PORTS*DATA_WIDTH-1:0] i_data;
    logic [PORTS-1:0]            i_last;
    logic [PORTS-1:0]            i_input_valid;
    logic                        i_output_ready;
    logic [DATA_WIDTH-1:0]       o_data;
    logic                        o_last;
    logic                        o_output_valid;
    logic [PORTS-1:0]            o_input_ready;
    logic [PORTS-1:0]            o_grant;
    logic                        o_locked;

    modport slave (
        input  i_data, i_last, i_input_valid, i_output_ready,
        output o_data, o_last, o_output_valid, o_input_ready, o_grant, o_locked
    );

    modport master (
        output i_data, i_last, i_input_valid, i_output_ready,
        input  o_data, o_last, o_output_valid, o_input_ready, o_grant, o_locked
    );
endinterface

// File: rtl/burst_ring_arbiter.sv
// Packet-granular round-robin arbiter, one-cycle latency through a 2-entry output buffer.
// Input ready is the buffer's registered not-full flag, so a full buffer stalls every port.
module burst_ring_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_aresetn,
    input  logic                  i_clear,
    burst_ring_arbiter_if.slave   arb_if
);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         lock_q, lock_d;
    logic [PW-1:0]         scan_idx, pick_idx, cur_idx;
    logic                  pick_found;
    logic [PORTS-1:0]      grant, in_rdy;
    logic                  buf_rdy, accept, beat_last;
    logic [DATA_WIDTH-1:0] beat_data;

    logic [DATA_WIDTH:0]   mem_q [2];
    logic                  wr_q, rd_q;
    logic [1:0]            cnt_q, cnt_d;
    logic                  pop;

    // First valid port at or after the priority pointer, wrapping.
    always_comb begin
        scan_idx   = '0;
        pick_idx   = ptr_q;
        pick_found = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            scan_idx = PW'((int'(ptr_q) + i) % PORTS);
            if (!pick_found && arb_if.i_input_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Ready only depends on registered occupancy, never on the same-cycle drain.
    assign buf_rdy = (cnt_q != 2'd2) & i_aresetn;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_d    = lock_q;
        grant     = '0;
        beat_data = '0;
        cur_idx   = (state_q == LOCKED) ? lock_q : pick_idx;
        if (state_q == LOCKED || pick_found) begin
            grant[cur_idx] = 1'b1;
        end
        in_rdy    = grant & {PORTS{buf_rdy & ~i_clear}};
        accept    = |(arb_if.i_input_valid & in_rdy);
        beat_last = arb_if.i_last[cur_idx];
        for (int p = 0; p < PORTS; p++) begin
            if (PW'(p) == cur_idx) begin
                beat_data = arb_if.i_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (accept) begin
            if (beat_last) begin
                state_d = IDLE;
                ptr_d   = (cur_idx == PW'(PORTS-1)) ? '0 : cur_idx + 1'b1;
            end else begin
                state_d = LOCKED;
                lock_d  = cur_idx;
            end
        end
        if (i_clear) begin
            state_d = IDLE;
            ptr_d   = '0;
            lock_d  = '0;
        end
    end

    assign pop = (cnt_q != 2'd0) & arb_if.i_output_ready;

    always_comb begin
        cnt_d = cnt_q + {1'b0, accept} - {1'b0, pop};
        if (i_clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            if (i_clear) begin
                wr_q <= 1'b0;
                rd_q <= 1'b0;
            end else begin
                if (accept) wr_q <= ~wr_q;
                if (pop)    rd_q <= ~rd_q;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (accept) begin
            mem_q[wr_q] <= {beat_last, beat_data};
        end
    end

    // Outputs are forced to zero when empty so reset and clear present a clean bus.
    assign arb_if.o_output_valid = (cnt_q != 2'd0);
    assign arb_if.o_data         = arb_if.o_output_valid ? mem_q[rd_q][DATA_WIDTH-1:0] : '0;
    assign arb_if.o_last         = arb_if.o_output_valid & mem_q[rd_q][DATA_WIDTH];
    assign arb_if.o_input_ready  = in_rdy;
    assign arb_if.o_grant        = grant;
    assign arb_if.o_locked       = (state_q == LOCKED);
endmodule

// File: tb/tb_burst_ring_arbiter.sv
// Directed bench for burst_ring_arbiter: round-robin, lock, bubble, backpressure, clear, async reset.
module tb_burst_ring_arbiter;
    logic clk = 1'b0;
    logic arst_n;
    logic clr;
    int   checks   = 0;
    int   failures = 0;

    burst_ring_arbiter_if #(.PORTS(4), .DATA_WIDTH(8)) bus ();

    burst_ring_arbiter #(.PORTS(4), .DATA_WIDTH(8)) dut (
        .i_clock   (clk),
        .i_aresetn (arst_n),
        .i_clear   (clr),
        .arb_if    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dat(input int p, input logic [7:0] v);
        bus.i_data[p*8 +: 8] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n             = 1'b0;
        clr                = 1'b0;
        bus.i_data         = '0;
        bus.i_last         = '0;
        bus.i_input_valid  = 4'b0100;
        bus.i_output_ready = 1'b1;
        #3;
        chk("rst_grant",  32'(bus.o_grant), 32'h4);
        chk("rst_in_rdy", 32'(bus.o_input_ready), 32'h0);
        chk("rst_ovld",   32'(bus.o_output_valid), 32'h0);
        chk("rst_odata",  32'(bus.o_data), 32'h0);
        chk("rst_olast",  32'(bus.o_last), 32'h0);
        chk("rst_locked", 32'(bus.o_locked), 32'h0);
        bus.i_input_valid = '0;
        #9;
        arst_n = 1'b1;
        tick();

        // Round-robin over single-beat packets, one beat per cycle.
        for (int p = 0; p < 4; p++) set_dat(p, {4'(p), 4'h1});
        bus.i_last        = 4'b1111;
        bus.i_input_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", 32'(bus.o_grant), 32'(1 << (k % 4)));
            tick();
            chk("rr_ovld", 32'(bus.o_output_valid), 32'h1);
            chk("rr_odata", 32'(bus.o_data), 32'({4'(k % 4), 4'h1}));
        end
        bus.i_input_valid = '0;
        tick();
        chk("rr_drain", 32'(bus.o_output_valid), 32'h0);

        // Port 1 three-beat packet while port 2 waits.
        set_dat(1, 8'h11);
        set_dat(2, 8'h2A);
        bus.i_last        = 4'b0100;
        bus.i_input_valid = 4'b0110;
        #1;
        chk("lk_grant0", 32'(bus.o_grant), 32'h2);
        chk("lk_lock0",  32'(bus.o_locked), 32'h0);
        tick();
        chk("lk_lock1",  32'(bus.o_locked), 32'h1);
        chk("lk_b1",     32'(bus.o_data), 32'h11);
        set_dat(1, 8'h12);
        #1;
        chk("lk_grant1", 32'(bus.o_grant), 32'h2);
        tick();
        chk("lk_lock2",  32'(bus.o_locked), 32'h1);
        chk("lk_b2",     32'(bus.o_data), 32'h12);
        chk("lk_b2last", 32'(bus.o_last), 32'h0);
        set_dat(1, 8'h13);
        bus.i_last = 4'b0110;
        tick();
        chk("lk_lock3",  32'(bus.o_locked), 32'h0);
        chk("lk_b3",     32'(bus.o_data), 32'h13);
        chk("lk_b3last", 32'(bus.o_last), 32'h1);
        bus.i_input_valid = 4'b0100;
        #1;
        chk("lk_grant2", 32'(bus.o_grant), 32'h4);
        tick();
        chk("lk_p2",     32'(bus.o_data), 32'h2A);
        chk("lk_p2last", 32'(bus.o_last), 32'h1);
        bus.i_input_valid = '0;
        tick();

        // Port 0 valid bubbles mid-packet while port 3 is valid.
        set_dat(0, 8'h01);
        set_dat(3, 8'h3F);
        bus.i_last        = 4'b1000;
        bus.i_input_valid = 4'b0001;
        #1;
        chk("bb_grant0", 32'(bus.o_grant), 32'h1);
        tick();
        chk("bb_lock",   32'(bus.o_locked), 32'h1);
        chk("bb_b1",     32'(bus.o_data), 32'h01);
        bus.i_input_valid = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bb_hold",   32'(bus.o_grant), 32'h1);
            tick();
            chk("bb_noacc",  32'(bus.o_output_valid), 32'h0);
        end
        set_dat(0, 8'h02);
        bus.i_last        = 4'b1001;
        bus.i_input_valid = 4'b1001;
        #1;
        chk("bb_grant1", 32'(bus.o_grant), 32'h1);
        tick();
        chk("bb_b2",     32'(bus.o_data), 32'h02);
        chk("bb_unlock", 32'(bus.o_locked), 32'h0);
        chk("bb_grant3", 32'(bus.o_grant), 32'h8);
        bus.i_input_valid = 4'b1000;
        tick();
        chk("bb_p3",     32'(bus.o_data), 32'h3F);
        bus.i_input_valid = '0;
        tick();

        // Five cycles of downstream stall with port 0 streaming.
        bus.i_output_ready = 1'b0;
        bus.i_last         = 4'b0001;
        bus.i_input_valid  = 4'b0001;
        set_dat(0, 8'hA0);
        #1;
        chk("bp_rdy0", 32'(bus.o_input_ready), 32'h1);
        tick();
        chk("bp_ovld", 32'(bus.o_output_valid), 32'h1);
        chk("bp_d0",   32'(bus.o_data), 32'hA0);
        set_dat(0, 8'hA1);
        tick();
        set_dat(0, 8'hA2);
        for (int c = 0; c < 3; c++) begin
            chk("bp_full", 32'(bus.o_input_ready), 32'h0);
            chk("bp_hold", 32'(bus.o_data), 32'hA0);
            tick();
        end
        chk("bp_full5", 32'(bus.o_input_ready), 32'h0);
        bus.i_output_ready = 1'b1;
        tick();
        chk("bp_d1",   32'(bus.o_data), 32'hA1);
        chk("bp_rdy1", 32'(bus.o_input_ready), 32'h1);
        tick();
        chk("bp_d2",   32'(bus.o_data), 32'hA2);
        bus.i_input_valid = '0;
        tick();
        chk("bp_empty", 32'(bus.o_output_valid), 32'h0);

        // Clear during a locked port-2 packet.
        set_dat(2, 8'h21);
        set_dat(0, 8'h0C);
        bus.i_last        = 4'b0001;
        bus.i_input_valid = 4'b0100;
        tick();
        chk("cl_lock", 32'(bus.o_locked), 32'h1);
        bus.i_input_valid = 4'b0101;
        clr = 1'b1;
        #1;
        chk("cl_rdy",  32'(bus.o_input_ready), 32'h0);
        tick();
        clr = 1'b0;
        chk("cl_ovld", 32'(bus.o_output_valid), 32'h0);
        chk("cl_lock0", 32'(bus.o_locked), 32'h0);
        #1;
        chk("cl_grant", 32'(bus.o_grant), 32'h1);
        bus.i_input_valid = 4'b0001;
        tick();
        chk("cl_p0",   32'(bus.o_data), 32'h0C);
        bus.i_input_valid = '0;
        tick();

        // Asynchronous reset between clock edges.
        set_dat(0, 8'h05);
        bus.i_last        = '0;
        bus.i_input_valid = 4'b0001;
        tick();
        chk("ar_pre",  32'(bus.o_output_valid), 32'h1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("ar_ovld",  32'(bus.o_output_valid), 32'h0);
        chk("ar_odata", 32'(bus.o_data), 32'h0);
        chk("ar_lock",  32'(bus.o_locked), 32'h0);
        chk("ar_rdy",   32'(bus.o_input_ready), 32'h0);
        chk("ar_grant", 32'(bus.o_grant), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/burst_ring_arbiter.md
BURST_RING_ARBITER -- requirements
Module: burst_ring_arbiter

Interface
REQ-001 Parameter PORTS, default 4: number of requester ports; SHALL be >= 2.
REQ-002 Parameter DATA_WIDTH, default 8: width of one data beat.
REQ-003 i_clock  input  1  clock; all state SHALL update on its rising edge.
REQ-004 i_aresetn  input  1  reset, asynchronous, active-low.
REQ-005 i_clear  input  1  synchronous clear, active-high.
REQ-006 i_data  input  PORTS*DATA_WIDTH  flattened request data; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-007 i_last  input  PORTS  per-port end-of-packet flag qualifying the current beat.
REQ-008 i_input_valid  input  PORTS  per-port beat valid.
REQ-009 i_output_ready  input  1  downstream ready.
REQ-010 o_data  output  DATA_WIDTH  output beat data.
REQ-011 o_last  output  1  output beat end-of-packet flag.
REQ-012 o_output_valid  output  1  output beat valid.
REQ-013 o_input_ready  output  PORTS  per-port ready; at most one bit set.
REQ-014 o_grant  output  PORTS  one-hot current grant, or zero when no port is granted.
REQ-015 o_locked  output  1  high while a multi-beat packet holds the grant.

Function
REQ-016 The block SHALL arbitrate at packet granularity: once a port's first beat is accepted, no other port SHALL be accepted until that port's beat with i_last=1 is accepted.
REQ-017 FSM states SHALL be IDLE and LOCKED; IDLE is the only reset state.
REQ-018 IDLE: o_grant SHALL be the highest-priority valid port, combinationally; zero if no port is valid.
REQ-019 Priority SHALL be round-robin: after a packet from port k completes, port (k+1) mod PORTS is highest, then ascending with wrap; after reset or clear, port 0 is highest.
REQ-020 LOCKED: o_grant SHALL equal the locked port regardless of other ports' valids; a deasserted valid on the locked port SHALL stall, not release, the grant.
REQ-021 Beat accept SHALL occur when (i_input_valid & o_input_ready) != 0; o_input_ready SHALL equal o_grant gated by output-stage ready and by !i_clear.
REQ-022 IDLE accept with i_last=0 SHALL go to LOCKED on the granted port; IDLE accept with i_last=1 SHALL stay in IDLE and advance the priority pointer.
REQ-023 LOCKED accept with i_last=1 SHALL return to IDLE and advance the pointer; LOCKED accept with i_last=0 SHALL stay in LOCKED.
REQ-024 The pointer SHALL update only on an accepted last beat.
REQ-025 The output stage SHALL be a 2-entry skid buffer carrying {data, last}, and SHALL be ready when it is not full.
REQ-026 An accepted beat SHALL appear on o_data/o_last with o_output_valid one cycle after acceptance when the buffer is empty.
REQ-027 Sustained throughput SHALL be one beat per cycle while i_output_ready=1; there SHALL be no idle cycle between packets from different ports.
REQ-028 An output transfer SHALL occur when o_output_valid & i_output_ready; while stalled, o_data and o_last SHALL hold.
REQ-029 Beats SHALL leave in acceptance order with no loss or duplication; a buffer that is simultaneously full and draining SHALL accept no new beat that cycle, i.e. ready is registered.
REQ-030 o_locked SHALL be high exactly in LOCKED.

Reset
REQ-031 On i_aresetn low, the block SHALL asynchronously enter IDLE with the pointer at port 0, empty the buffer, and drive o_output_valid=0, o_data=0, o_last=0, o_locked=0, o_input_ready=0.
REQ-032 On i_clear high at a clock edge, the block SHALL apply the same state as reset synchronously, and SHALL discard any beat presented in that cycle.
REQ-033 Reset or clear during LOCKED SHALL abandon the partial packet; the next grant SHALL follow REQ-019 from port 0.
REQ-034 While i_aresetn is low, o_grant SHALL still reflect the IDLE combinational choice, and o_input_ready SHALL be 0.

Verification
REQ-035 Round-robin: PORTS=4, all ports valid with single-beat packets, ready=1 -> output order 0,1,2,3,0,..., one beat per cycle.
REQ-036 Lock: port 1 sends a 3-beat packet while port 2 is valid -> three port-1 beats, the third with o_last=1, then port 2; o_locked high from the cycle after beat 1 is accepted until the cycle after beat 3 is accepted.
REQ-037 Bubble in lock: port 0 valid drops for 2 cycles mid-packet while port 3 is valid -> o_grant stays 4'b0001 and no port-3 beat is accepted before port 0's last beat.
REQ-038 Backpressure: i_output_ready=0 for 5 cycles -> at most 2 beats buffered, o_input_ready=0 afterwards, and on release the beats emerge in order without loss.
REQ-039 Clear mid-packet: i_clear for 1 cycle during a LOCKED port-2 packet -> o_output_valid=0 and o_locked=0 the next cycle, and the next grant goes to port 0 if valid.
REQ-040 Async reset asserted mid-cycle -> outputs zero immediately, without waiting for a clock edge.
